// File: rtl/vga_tile_scroller.sv
// vga_tile_scroller: VGA timing plus a horizontally scrolling tile-map renderer
// fetching tile IDs and atlas pixels through a fixed 5-stage pipeline.
module vga_tile_scroller #(
    parameter int H_SYNC = 112,
    parameter int H_BACK = 248,
    parameter int H_ACTIVE = 1280,
    parameter int H_FRONT = 48,
    parameter int V_SYNC = 3,
    parameter int V_BACK = 38,
    parameter int V_ACTIVE = 1024,
    parameter int V_FRONT = 1,
    parameter int TILE_LOG2 = 6,
    parameter int MAP_W = 212,
    parameter int MAP_H = 14,
    parameter int ATLAS_W = 640,
    parameter int ID_W = 6,
    parameter int MAP_AW = 12,
    parameter int PIX_AW = 18,
    parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       scroll_x,
    input  logic [11:0]       bg_color,
    output logic [MAP_AW-1:0] map_addr,
    input  logic [ID_W-1:0]   map_data,
    output logic [PIX_AW-1:0] pix_addr,
    input  logic [15:0]       pix_data,
    output logic [3:0]        O_red,
    output logic [3:0]        O_green,
    output logic [3:0]        O_blue,
    output logic              hs,
    output logic              vs,
    output logic              frame_start
);
    localparam logic [15:0] H_MAX = 16'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
    localparam logic [15:0] V_MAX = 16'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
    localparam logic [15:0] H_ORG = 16'(H_SYNC + H_BACK);
    localparam logic [15:0] V_ORG = 16'(V_SYNC + V_BACK);
    localparam logic [15:0] H_VIS = 16'(H_ACTIVE);
    localparam logic [15:0] V_VIS = 16'(V_ACTIVE);
    localparam logic [15:0] HS_W = 16'(H_SYNC);
    localparam logic [15:0] VS_W = 16'(V_SYNC);
    localparam logic [15:0] Y_MAP = 16'(MAP_H << TILE_LOG2);
    localparam logic [15:0] S_MAX = 16'((MAP_W << TILE_LOG2) - H_ACTIVE);
    localparam int TPR = ATLAS_W >> TILE_LOG2;
    localparam int TS = 1 << TILE_LOG2;

    logic [15:0] h_cnt, v_cnt, sx_lat, x, y, wx;
    logic [TILE_LOG2-1:0] fx1, fy1, fx2, fy2;
    logic act0, act1, act2, act3, act4;
    logic inmap1, inmap2, inmap3, inmap4, skip3, skip4, origin;
    logic [4:0] hs_d, vs_d;
    logic [31:0] id;

    always_comb begin
        x = h_cnt - H_ORG;
        y = v_cnt - V_ORG;
        wx = x + sx_lat;
        act0 = (h_cnt >= H_ORG) && (x < H_VIS) && (v_cnt >= V_ORG) && (y < V_VIS);
        origin = (h_cnt == '0) && (v_cnt == '0);
        id = 32'(map_data);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
            sx_lat <= '0;
            frame_start <= 1'b0;
            map_addr <= '0;
            pix_addr <= '0;
            {fx1, fy1, fx2, fy2} <= '0;
            {act1, act2, act3, act4} <= '0;
            {inmap1, inmap2, inmap3, inmap4, skip3, skip4} <= '0;
            {O_red, O_green, O_blue} <= '0;
            hs_d <= '0;
            vs_d <= '0;
        end else begin
            h_cnt <= (h_cnt == H_MAX) ? '0 : h_cnt + 16'd1;
            if (h_cnt == H_MAX)
                v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 16'd1;
            frame_start <= origin;
            // latched only at the frame origin so a whole frame scrolls as one
            if (origin)
                sx_lat <= (scroll_x > S_MAX) ? S_MAX : scroll_x;
            map_addr <= MAP_AW'(32'(y >> TILE_LOG2) * MAP_W + 32'(wx >> TILE_LOG2));
            fx1 <= wx[TILE_LOG2-1:0];
            fy1 <= y[TILE_LOG2-1:0];
            inmap1 <= y < Y_MAP;
            act1 <= act0;
            {fx2, fy2, inmap2, act2} <= {fx1, fy1, inmap1, act1};
            pix_addr <= PIX_AW'((id / TPR) * (ATLAS_W << TILE_LOG2) + (id % TPR) * TS
                                + 32'(fy2) * ATLAS_W + 32'(fx2));
            skip3 <= map_data == '0;
            {inmap3, act3} <= {inmap2, act2};
            {inmap4, act4, skip4} <= {inmap3, act3, skip3};
            {O_red, O_green, O_blue} <= !act4 ? 12'h000
                : (!inmap4 || skip4 || pix_data == KEY_COLOR) ? bg_color
                : {pix_data[15:12], pix_data[10:7], pix_data[4:1]};
            hs_d <= {hs_d[3:0], h_cnt >= HS_W};
            vs_d <= {vs_d[3:0], v_cnt >= VS_W};
        end
    end

    assign hs = hs_d[4];
    assign vs = vs_d[4];
endmodule

// File: doc/vga_tile_scroller.md
# vga_tile_scroller

Parametrised VGA tile-map renderer that generates sync timing and draws a scrolling tile world. It fetches tile IDs from an external map ROM and tile pixels from an external atlas ROM through a fixed 5-stage pipeline. It adds pixel-accurate horizontal scrolling latched once per frame, a transparency key and a background colour, and an empty-tile skip. It sits between the game-state logic, which drives scroll position, and the VGA pins.

## Interface
Parameters:
- H_SYNC, 112: hsync pulse width in clocks.
- H_BACK, 248: horizontal back porch.
- H_ACTIVE, 1280: visible pixels per line.
- H_FRONT, 48: horizontal front porch.
- V_SYNC, 3: vsync pulse width in lines.
- V_BACK, 38: vertical back porch.
- V_ACTIVE, 1024: visible lines.
- V_FRONT, 1: vertical front porch.
- TILE_LOG2, 6: tile edge is 2^TILE_LOG2 pixels.
- MAP_W, 212: map width in tiles.
- MAP_H, 14: map height in tiles.
- ATLAS_W, 640: atlas ROM row stride in pixels; tiles per atlas row TPR = ATLAS_W >> TILE_LOG2.
- ID_W, 6: tile ID width.
- MAP_AW, 12: map ROM address width.
- PIX_AW, 18: atlas ROM address width.
- KEY_COLOR, 16'hF81F: RGB565 transparent colour.

Ports:
- clk, in, 1: pixel clock.
- rst, in, 1: reset. Asynchronous, active-low.
- scroll_x, in, 16: world x of the left screen edge, in pixels.
- bg_color, in, 12: background colour {R4,G4,B4}.
- map_addr, out, MAP_AW: map ROM address.
- map_data, in, ID_W: tile ID, valid one clock after map_addr.
- pix_addr, out, PIX_AW: atlas ROM address.
- pix_data, in, 16: RGB565 pixel, valid one clock after pix_addr.
- O_red / O_green / O_blue, out, 4 each: VGA colour.
- hs, out, 1: hsync, active low.
- vs, out, 1: vsync, active low.
- frame_start, out, 1: one-clock pulse when h_cnt = 0 and v_cnt = 0.

## Operation
- **Counters (stage 0)**
  - h_cnt wraps at H_TOTAL-1.
  - v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL-1.
  - H_TOTAL and V_TOTAL are the sum of the four respective parameters.
  - Active region: h_cnt in [H_SYNC+H_BACK, +H_ACTIVE-1] and v_cnt in [V_SYNC+V_BACK, +V_ACTIVE-1].
  - Screen coordinates are x = h_cnt-(H_SYNC+H_BACK) and y = v_cnt-(V_SYNC+V_BACK).
- **Scroll latch**
  - At h_cnt = 0, v_cnt = 0, sx_lat <= min(scroll_x, SMAX), where SMAX = (MAP_W << TILE_LOG2) - H_ACTIVE.
  - Changes to scroll_x at any other time have no effect until the next frame.
- **World coordinate**
  - wx = x + sx_lat.
  - Tile column = wx >> TILE_LOG2; tile row = y >> TILE_LOG2.
  - Fine offsets fx and fy are the low TILE_LOG2 bits of wx and y.
- **Stage 1**
  - map_addr <= row*MAP_W + col.
  - fx, fy, the in-map flag (y < MAP_H << TILE_LOG2) and the active flag are registered alongside.
- **Stage 2**
  - map_data is valid.
  - Side-band signals are delayed one clock.
- **Stage 3**
  - pix_addr <= (id/TPR)*(ATLAS_W << TILE_LOG2) + (id%TPR)*2^TILE_LOG2 + fy*ATLAS_W + fx.
  - A flag skip = (id == 0) is registered.
- **Stage 4**
  - pix_data is valid.
- **Stage 5 colour select** (first matching rule wins):
  - not active: 0.
  - not in-map, or skip: bg_color.
  - pix_data == KEY_COLOR: bg_color.
  - otherwise: {pix_data[15:12], pix_data[10:7], pix_data[4:1]}.
- **Sync outputs**
  - hs = ~(h_cnt < H_SYNC) and vs = ~(v_cnt < V_SYNC).
  - Both pass through a 5-stage delay line so they stay aligned with colour.
- **Arithmetic:** all address products are computed at full width and then truncated to MAP_AW or PIX_AW. Out-of-range addresses never occur when the parameters are consistent.

## Timing
- **Reset:** all counters, pipeline registers, sx_lat, map_addr, pix_addr, O_*, hs, vs and frame_start are 0. Outputs stay 0 until the pipeline fills (5 clocks after rst is released).
- **Latency:** exactly 5 clocks from counter value to the O_*, hs and vs pins. map_addr lags the counter by 1 clock; pix_addr lags by 3 clocks.
- **frame_start:** undelayed, driven from stage 0. It is a single clock per frame.
- **Wrap-around:** frame_start, the scroll latch and the counter wrap all occur on the same clock. The new sx_lat applies to the whole new frame, including the first active pixel.
- **Reset mid-frame:** counters restart at 0 and the pipeline is cleared. The first frame_start pulse comes 1 clock after release.

## Test plan
- **Reset:** hold rst = 0 for 10 clocks, then release. All outputs are 0 while held, and frame_start pulses on the first clock after release.
- **Sync timing (default parameters):**
  - hs period is 1688 clocks with a low time of 112 clocks.
  - vs period is 1066 lines with a low time of 3 lines.
  - Both lag the counters by 5 clocks.
- **Static draw:**
  - Setup: scroll_x = 0, map ROM all ID 1, atlas pixel (64,0) = 16'hFFFF.
  - First active pixel: map_addr = 0 and pix_addr = 64.
  - Colour: the colour 5 clocks later is 0xF/0xF/0xF.
- **Fine scroll:**
  - scroll_x = 70 gives map_addr = 1 and fx = 6 at x = 0.
  - At x = 58, map_addr = 2 and fx = 0.
- **Clamp and latch:**
  - scroll_x = 16'hFFFF gives sx_lat = 12288.
  - Changing scroll_x mid-frame leaves map_addr unchanged until after the next frame_start.
- **Background substitution:**
  - A pixel equal to KEY_COLOR outputs bg_color = 12'h5AF.
  - Tile ID 0 outputs bg_color.
  - Lines with y ≥ 896 output bg_color.
  - Blanking outputs 0.
